// File: rtl/qam16_slicer_lock.sv
// qam16_slicer_lock: 16-QAM symbol slicer with Gray mapping, per-axis
// decision error, and a windowed mean-|error| lock detector with hysteresis.
module qam16_slicer_lock #(
  parameter int DATA_WIDTH   = 12,
  parameter int LVL1         = 341,
  parameter int LVL3         = 1024,
  parameter int THRESH       = 682,
  parameter int WIN_LOG2     = 6,
  parameter int LOCK_THR     = 120,
  parameter int UNLOCK_THR   = 200,
  parameter int CONFIRM_WINS = 3,
  parameter int MISS_WINS    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] sym_I,
  input  logic signed [DATA_WIDTH-1:0] sym_Q,
  input  logic                         sym_strobe,
  output logic signed [DATA_WIDTH-1:0] dec_I,
  output logic signed [DATA_WIDTH-1:0] dec_Q,
  output logic [3:0]                   dec_bits,
  output logic signed [DATA_WIDTH:0]   err_I,
  output logic signed [DATA_WIDTH:0]   err_Q,
  output logic                         dec_valid,
  output logic [DATA_WIDTH+1:0]        metric,
  output logic                         metric_valid,
  output logic [1:0]                   lock_state,
  output logic                         locked
);

  localparam int DW = DATA_WIDTH;
  localparam int EW = DATA_WIDTH + 1;
  localparam int MW = DATA_WIDTH + 2;
  localparam int AW = DATA_WIDTH + 10;

  localparam logic signed [EW-1:0] LVL1_E   = EW'(LVL1);
  localparam logic signed [EW-1:0] LVL3_E   = EW'(LVL3);
  localparam logic signed [EW-1:0] THRESH_E = EW'(THRESH);
  localparam logic [MW-1:0]        LOCK_T   = MW'(LOCK_THR);
  localparam logic [MW-1:0]        UNLOCK_T = MW'(UNLOCK_THR);
  localparam logic [7:0]           CONFIRM_T = 8'(CONFIRM_WINS);
  localparam logic [7:0]           MISS_T    = 8'(MISS_WINS);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    VERIFY  = 2'd1,
    LOCKED  = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  // Magnitude in the widened domain so that the most negative input is representable.
  function automatic logic signed [EW-1:0] mag_of(input logic signed [EW-1:0] v);
    return v[EW-1] ? -v : v;
  endfunction

  // Nearest 16-QAM level on one axis; zero slices to the positive side.
  function automatic logic signed [EW-1:0] slice_lvl(input logic signed [EW-1:0] xe);
    logic signed [EW-1:0] lvl;
    lvl = (mag_of(xe) >= THRESH_E) ? LVL3_E : LVL1_E;
    return xe[EW-1] ? -lvl : lvl;
  endfunction

  logic signed [EW-1:0] sym_i_e, sym_q_e;
  logic signed [EW-1:0] lvl_i, lvl_q;
  logic signed [EW-1:0] err_i_n, err_q_n;
  logic [1:0]           bits_i, bits_q;
  logic [EW-1:0]        abs_err_i, abs_err_q;
  logic [MW-1:0]        term;
  logic [AW-1:0]        win_sum;
  logic [MW-1:0]        m_new;
  logic                 win_end;
  logic [WIN_LOG2-1:0]  sym_cnt;
  logic [AW-1:0]        acc;
  state_t               state;
  logic [7:0]           good_cnt, miss_cnt;
  logic [7:0]           good_inc, miss_inc;

  // Slicer decisions, Gray bits, errors and window arithmetic.
  always_comb begin
    sym_i_e   = {sym_I[DW-1], sym_I};
    sym_q_e   = {sym_Q[DW-1], sym_Q};
    lvl_i     = slice_lvl(sym_i_e);
    lvl_q     = slice_lvl(sym_q_e);
    err_i_n   = sym_i_e - lvl_i;
    err_q_n   = sym_q_e - lvl_q;
    bits_i    = {~sym_I[DW-1], (mag_of(sym_i_e) < THRESH_E)};
    bits_q    = {~sym_Q[DW-1], (mag_of(sym_q_e) < THRESH_E)};
    abs_err_i = mag_of(err_I);
    abs_err_q = mag_of(err_Q);
    term      = MW'(abs_err_i) + MW'(abs_err_q);
    win_sum   = acc + AW'(term);
    m_new     = MW'(win_sum >> WIN_LOG2);
    win_end   = dec_valid && (sym_cnt == '1);
    good_inc  = (good_cnt == '1) ? good_cnt : good_cnt + 8'd1;
    miss_inc  = (miss_cnt == '1) ? miss_cnt : miss_cnt + 8'd1;
  end

  // Decision register: one stage after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_I     <= '0;
      dec_Q     <= '0;
      dec_bits  <= '0;
      err_I     <= '0;
      err_Q     <= '0;
      dec_valid <= 1'b0;
    end else begin
      dec_valid <= sym_strobe;
      if (sym_strobe) begin
        dec_I    <= lvl_i[DW-1:0];
        dec_Q    <= lvl_q[DW-1:0];
        dec_bits <= {bits_i, bits_q};
        err_I    <= err_i_n;
        err_Q    <= err_q_n;
      end
    end
  end

  // Window accumulator: the closing symbol's term is folded into the metric
  // and the accumulator restarts at zero, so no sample is lost between windows.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      sym_cnt      <= '0;
      metric       <= '0;
      metric_valid <= 1'b0;
    end else begin
      metric_valid <= 1'b0;
      if (win_end) begin
        metric       <= m_new;
        metric_valid <= 1'b1;
        acc          <= '0;
        sym_cnt      <= '0;
      end else if (dec_valid) begin
        acc     <= win_sum;
        sym_cnt <= sym_cnt + 1'b1;
      end
    end
  end

  // Lock FSM, stepped once per completed window with the fresh metric.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SEARCH;
      good_cnt <= '0;
      miss_cnt <= '0;
      locked   <= 1'b0;
    end else if (win_end) begin
      case (state)
        SEARCH: begin
          if (m_new < LOCK_T) begin
            if (CONFIRM_T <= 8'd1) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= '0;
              miss_cnt <= '0;
            end else begin
              state    <= VERIFY;
              good_cnt <= 8'd1;
            end
          end
        end
        VERIFY: begin
          if (m_new < LOCK_T) begin
            if (good_inc >= CONFIRM_T) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= '0;
              miss_cnt <= '0;
            end else begin
              good_cnt <= good_inc;
            end
          end else begin
            state    <= SEARCH;
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if (m_new > UNLOCK_T) begin
            if (miss_inc >= MISS_T) begin
              state    <= SEARCH;
              locked   <= 1'b0;
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_inc;
            end
          end else begin
            miss_cnt <= '0;
          end
        end
        default: begin
          state    <= SEARCH;
          locked   <= 1'b0;
          good_cnt <= '0;
          miss_cnt <= '0;
        end
      endcase
    end
  end

  assign lock_state = state;

endmodule
